// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_src_e   : request sources (i-cache read, d-cache read, d-cache write);
//                 the enum value is also the bit index into the grant vector
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CMD  = 2'd1,
      RD_DATA = 2'd2,
      WR_CMD  = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      SRC_IC = 2'd0,
      SRC_DR = 2'd1,
      SRC_DW = 2'd2
   } arb_src_e;

   localparam int NUM_SRC = 3;

endpackage

// File: rtl/mem_arbiter_picker.sv
// mem_arbiter_picker: combinational fairness selection between the
// instruction side and the data side.
//   ic_valid, dr_valid, dw_valid : pending requests
//   last_grant_d                 : previous grant went to the data side
//   grant                        : one-hot grant, indexed by arb_src_e
//   grant_any                    : some source is granted
module mem_arbiter_picker
   import mem_arbiter_pkg::*;
(
   input  logic               ic_valid,
   input  logic               dr_valid,
   input  logic               dw_valid,
   input  logic               last_grant_d,
   output logic [NUM_SRC-1:0] grant,
   output logic               grant_any
);

   logic d_valid;

   assign d_valid = dr_valid | dw_valid;

   // I and D alternate when both are pending; inside D the write wins
   // because the write-through d-cache must not stall on its own reads.
   always_comb begin
      grant = '0;
      if (ic_valid && (!d_valid || last_grant_d))
         grant[SRC_IC] = 1'b1;
      else if (dw_valid)
         grant[SRC_DW] = 1'b1;
      else if (dr_valid)
         grant[SRC_DR] = 1'b1;
   end

   assign grant_any = |grant;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises i-cache reads, d-cache reads and d-cache writes
// onto one external memory command port and routes read bursts back.
//   clk, rst                 : clock, asynchronous active-high reset
//   ic_rd_req_* / ic_rd_data* : i-cache line read request / returned beats
//   dc_rd_req_* / dc_rd_data* : d-cache line read request / returned beats
//   dc_wr_req_*               : d-cache single-word write request
//   mem_cmd_*                 : command to memory (registered)
//   mem_rd_data*              : read beats from memory
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ic_rd_req_valid,
   input  logic [ADDR_WIDTH-1:0] ic_rd_req_addr,
   output logic                  ic_rd_req_ready,
   output logic                  ic_rd_data_valid,
   output logic [DATA_WIDTH-1:0] ic_rd_data,
   input  logic                  dc_rd_req_valid,
   input  logic [ADDR_WIDTH-1:0] dc_rd_req_addr,
   output logic                  dc_rd_req_ready,
   output logic                  dc_rd_data_valid,
   output logic [DATA_WIDTH-1:0] dc_rd_data,
   input  logic                  dc_wr_req_valid,
   input  logic [ADDR_WIDTH-1:0] dc_wr_req_addr,
   input  logic [DATA_WIDTH-1:0] dc_wr_req_data,
   output logic                  dc_wr_req_ready,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic                  mem_cmd_write,
   output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [DATA_WIDTH-1:0] mem_cmd_wdata,
   input  logic                  mem_rd_data_valid,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   localparam int CNT_W = $clog2(BURST_LEN);

   arb_state_e         state;
   arb_src_e           owner;
   logic               last_grant_d;
   logic [CNT_W-1:0]   beat_cnt;
   logic [NUM_SRC-1:0] grant;
   logic               grant_any;
   logic               idle;
   logic               beat;

   mem_arbiter_picker u_picker (
      .ic_valid     (ic_rd_req_valid),
      .dr_valid     (dc_rd_req_valid),
      .dw_valid     (dc_wr_req_valid),
      .last_grant_d (last_grant_d),
      .grant        (grant),
      .grant_any    (grant_any)
   );

   // rst gating keeps the handshakes quiet while reset is held, since the
   // async reset already forces state to IDLE.
   assign idle = (state == IDLE) && !rst;
   assign beat = (state == RD_DATA) && mem_rd_data_valid && !rst;

   assign ic_rd_req_ready = idle && grant[SRC_IC];
   assign dc_rd_req_ready = idle && grant[SRC_DR];
   assign dc_wr_req_ready = idle && grant[SRC_DW];

   assign ic_rd_data_valid = beat && (owner == SRC_IC);
   assign dc_rd_data_valid = beat && (owner == SRC_DR);
   assign ic_rd_data       = mem_rd_data;
   assign dc_rd_data       = mem_rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= SRC_IC;
         last_grant_d  <= 1'b0;
         beat_cnt      <= '0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_write <= 1'b0;
         mem_cmd_addr  <= '0;
         mem_cmd_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  mem_cmd_valid <= 1'b1;
                  if (grant[SRC_DW]) begin
                     owner         <= SRC_DW;
                     mem_cmd_addr  <= dc_wr_req_addr;
                     mem_cmd_wdata <= dc_wr_req_data;
                     mem_cmd_write <= 1'b1;
                     last_grant_d  <= 1'b1;
                     state         <= WR_CMD;
                  end else if (grant[SRC_DR]) begin
                     owner         <= SRC_DR;
                     mem_cmd_addr  <= dc_rd_req_addr;
                     mem_cmd_write <= 1'b0;
                     last_grant_d  <= 1'b1;
                     state         <= RD_CMD;
                  end else begin
                     owner         <= SRC_IC;
                     mem_cmd_addr  <= ic_rd_req_addr;
                     mem_cmd_write <= 1'b0;
                     last_grant_d  <= 1'b0;
                     state         <= RD_CMD;
                  end
               end
            end
            RD_CMD: begin
               if (mem_cmd_ready) begin
                  mem_cmd_valid <= 1'b0;
                  beat_cnt      <= '0;
                  state         <= RD_DATA;
               end
            end
            WR_CMD: begin
               if (mem_cmd_ready) begin
                  mem_cmd_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            RD_DATA: begin
               if (mem_rd_data_valid) begin
                  if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives random/directed requests and a memory responder,
// and compares the arbiter against a transaction-level model every cycle.
module tb_mem_arbiter;

   localparam int AW = 26;
   localparam int DW = 32;
   localparam int BL = 4;
   localparam int S_IC = 0;
   localparam int S_DR = 1;
   localparam int S_DW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ic_rd_req_valid = 1'b0;
   logic [AW-1:0] ic_rd_req_addr = '0;
   logic          ic_rd_req_ready;
   logic          ic_rd_data_valid;
   logic [DW-1:0] ic_rd_data;
   logic          dc_rd_req_valid = 1'b0;
   logic [AW-1:0] dc_rd_req_addr = '0;
   logic          dc_rd_req_ready;
   logic          dc_rd_data_valid;
   logic [DW-1:0] dc_rd_data;
   logic          dc_wr_req_valid = 1'b0;
   logic [AW-1:0] dc_wr_req_addr = '0;
   logic [DW-1:0] dc_wr_req_data = '0;
   logic          dc_wr_req_ready;
   logic          mem_cmd_valid;
   logic          mem_cmd_ready = 1'b0;
   logic          mem_cmd_write;
   logic [AW-1:0] mem_cmd_addr;
   logic [DW-1:0] mem_cmd_wdata;
   logic          mem_rd_data_valid = 1'b0;
   logic [DW-1:0] mem_rd_data = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst),
      .ic_rd_req_valid(ic_rd_req_valid), .ic_rd_req_addr(ic_rd_req_addr),
      .ic_rd_req_ready(ic_rd_req_ready), .ic_rd_data_valid(ic_rd_data_valid),
      .ic_rd_data(ic_rd_data),
      .dc_rd_req_valid(dc_rd_req_valid), .dc_rd_req_addr(dc_rd_req_addr),
      .dc_rd_req_ready(dc_rd_req_ready), .dc_rd_data_valid(dc_rd_data_valid),
      .dc_rd_data(dc_rd_data),
      .dc_wr_req_valid(dc_wr_req_valid), .dc_wr_req_addr(dc_wr_req_addr),
      .dc_wr_req_data(dc_wr_req_data), .dc_wr_req_ready(dc_wr_req_ready),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
      .mem_cmd_wdata(mem_cmd_wdata),
      .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data(mem_rd_data)
   );

   int n_chk = 0;
   int n_fail = 0;

   // requester queues (front = currently presented request)
   logic [AW-1:0] ic_q[$];
   logic [AW-1:0] dr_q[$];
   logic [AW-1:0] dw_qa[$];
   logic [DW-1:0] dw_qd[$];

   // memory responder controls
   int            rdy_pct = 100;
   int            beat_pct = 100;
   int            stall_left = 0;
   int            stray_left = 0;
   bit            rand_strays = 1'b0;
   bit            use_base = 1'b0;
   logic [DW-1:0] beat_base = '0;
   int            rd_hs_cnt = 0;
   int            beats_sent = 0;

   // observation logs
   int            cyc = 0;
   int            ic_dv_cnt = 0;
   int            dc_dv_cnt = 0;
   int            cmd_cyc = 0;
   int            ic_rdy_cyc = 0;
   bit            first_cmd_seen = 1'b0;
   int            first_cmd_cyc = 0;
   logic [AW-1:0] first_cmd_addr = '0;
   logic          first_cmd_wr = 1'b0;
   logic [DW-1:0] last_ic_data = '0;
   int            glog[$];
   logic [AW-1:0] hs_addr[$];
   logic          hs_wr[$];
   logic [DW-1:0] hs_wd[$];

   // transaction-level model: one outstanding transaction at most
   bit            m_busy = 1'b0;
   bit            m_pend = 1'b0;
   bit            m_read = 1'b0;
   int            m_owner = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   int            m_beats = 0;
   bit            m_last_d = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_cycle();
      int g;
      bit d_v, e_ic, e_dc;
      cyc++;
      chk("ic_rd_data passthru", 64'(ic_rd_data), 64'(mem_rd_data));
      chk("dc_rd_data passthru", 64'(dc_rd_data), 64'(mem_rd_data));
      if (rst) begin
         chk("reset handshakes", 64'({ic_rd_req_ready, dc_rd_req_ready, dc_wr_req_ready,
                                      ic_rd_data_valid, dc_rd_data_valid}), 64'(0));
         chk("reset cmd valid/write", 64'({mem_cmd_valid, mem_cmd_write}), 64'(0));
         chk("reset cmd addr", 64'(mem_cmd_addr), 64'(0));
         chk("reset cmd wdata", 64'(mem_cmd_wdata), 64'(0));
         m_busy = 0; m_pend = 0; m_last_d = 0; m_beats = 0;
      end else begin
         g = -1;
         if (!m_busy) begin
            d_v = dc_wr_req_valid || dc_rd_req_valid;
            if (ic_rd_req_valid && d_v) g = m_last_d ? S_IC : (dc_wr_req_valid ? S_DW : S_DR);
            else if (ic_rd_req_valid) g = S_IC;
            else if (dc_wr_req_valid) g = S_DW;
            else if (dc_rd_req_valid) g = S_DR;
         end
         chk("ic_rd_req_ready", 64'(ic_rd_req_ready), 64'(g == S_IC));
         chk("dc_rd_req_ready", 64'(dc_rd_req_ready), 64'(g == S_DR));
         chk("dc_wr_req_ready", 64'(dc_wr_req_ready), 64'(g == S_DW));
         if (ic_rd_req_ready) begin glog.push_back(S_IC); ic_rdy_cyc = cyc; end
         if (dc_rd_req_ready) glog.push_back(S_DR);
         if (dc_wr_req_ready) glog.push_back(S_DW);

         chk("mem_cmd_valid", 64'(mem_cmd_valid), 64'(m_busy && m_pend));
         if (m_busy && m_pend) begin
            chk("mem_cmd_write", 64'(mem_cmd_write), 64'(!m_read));
            chk("mem_cmd_addr", 64'(mem_cmd_addr), 64'(m_addr));
            if (!m_read) chk("mem_cmd_wdata", 64'(mem_cmd_wdata), 64'(m_wdata));
         end

         e_ic = m_busy && m_read && !m_pend && mem_rd_data_valid && (m_owner == S_IC);
         e_dc = m_busy && m_read && !m_pend && mem_rd_data_valid && (m_owner == S_DR);
         chk("ic_rd_data_valid", 64'(ic_rd_data_valid), 64'(e_ic));
         chk("dc_rd_data_valid", 64'(dc_rd_data_valid), 64'(e_dc));
         if (ic_rd_data_valid) begin ic_dv_cnt++; last_ic_data = ic_rd_data; end
         if (dc_rd_data_valid) dc_dv_cnt++;

         if (mem_cmd_valid) begin
            cmd_cyc++;
            if (!first_cmd_seen) begin
               first_cmd_seen = 1'b1;
               first_cmd_cyc  = cyc;
               first_cmd_addr = mem_cmd_addr;
               first_cmd_wr   = mem_cmd_write;
            end
            if (mem_cmd_ready) begin
               hs_addr.push_back(mem_cmd_addr);
               hs_wr.push_back(mem_cmd_write);
               hs_wd.push_back(mem_cmd_wdata);
               if (!mem_cmd_write) rd_hs_cnt++;
            end
         end

         // advance the model to the next cycle
         if (g >= 0) begin
            m_busy = 1; m_pend = 1; m_read = (g != S_DW); m_owner = g;
            m_last_d = (g != S_IC);
            m_addr = (g == S_IC) ? ic_rd_req_addr : (g == S_DR) ? dc_rd_req_addr : dc_wr_req_addr;
            m_wdata = dc_wr_req_data;
            if (g == S_IC) void'(ic_q.pop_front());
            else if (g == S_DR) void'(dr_q.pop_front());
            else begin void'(dw_qa.pop_front()); void'(dw_qd.pop_front()); end
         end else if (m_busy && m_pend) begin
            if (mem_cmd_ready) begin
               m_pend = 0; m_beats = 0;
               if (!m_read) m_busy = 0;
            end
         end else if (m_busy && m_read && mem_rd_data_valid) begin
            m_beats++;
            if (m_beats == BL) m_busy = 0;
         end
      end
   endtask

   task automatic drive();
      int owed;
      ic_rd_req_valid = ic_q.size() != 0;
      ic_rd_req_addr  = ic_rd_req_valid ? ic_q[0] : '0;
      dc_rd_req_valid = dr_q.size() != 0;
      dc_rd_req_addr  = dc_rd_req_valid ? dr_q[0] : '0;
      dc_wr_req_valid = dw_qa.size() != 0;
      dc_wr_req_addr  = dc_wr_req_valid ? dw_qa[0] : '0;
      dc_wr_req_data  = dc_wr_req_valid ? dw_qd[0] : '0;

      if (stall_left > 0 && mem_cmd_valid) begin
         mem_cmd_ready = 1'b0;
         stall_left--;
      end else begin
         mem_cmd_ready = ($urandom_range(99) < rdy_pct);
      end

      if (rst) beats_sent = rd_hs_cnt * BL;
      owed = rd_hs_cnt * BL - beats_sent;
      mem_rd_data_valid = 1'b0;
      mem_rd_data = $urandom;
      if (stray_left > 0) begin
         mem_rd_data_valid = 1'b1;
         stray_left--;
      end else if (owed > 0 && $urandom_range(99) < beat_pct) begin
         mem_rd_data_valid = 1'b1;
         if (use_base) mem_rd_data = beat_base + DW'(beats_sent % BL);
         beats_sent++;
      end else if (rand_strays && owed == 0 && $urandom_range(99) < 5) begin
         mem_rd_data_valid = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ic_q.delete(); dr_q.delete(); dw_qa.delete(); dw_qd.delete();
      stall_left = 0; stray_left = 0;
      tick(); tick();
      rst = 1'b0;
      glog.delete(); hs_addr.delete(); hs_wr.delete(); hs_wd.delete();
      ic_dv_cnt = 0; dc_dv_cnt = 0; cmd_cyc = 0;
      tick();
   endtask

   task automatic run_grants(input int n, input string nm);
      for (int i = 0; i < 400 && glog.size() < n; i++) tick();
      chk({nm, " grant count"}, 64'(glog.size() >= n), 64'(1));
   endtask

   task automatic settle(input string nm);
      for (int i = 0; i < 400 && (m_busy || ic_q.size() != 0 || dr_q.size() != 0 ||
                                  dw_qa.size() != 0); i++) tick();
      chk({nm, " drained"}, 64'(m_busy || ic_q.size() != 0 || dr_q.size() != 0 ||
                                dw_qa.size() != 0), 64'(0));
   endtask

   initial begin
      int exp6[6];
      int cmd0;
      exp6[0] = S_DR; exp6[1] = S_IC; exp6[2] = S_DR;
      exp6[3] = S_IC; exp6[4] = S_DR; exp6[5] = S_IC;

      do_reset();

      // single i-cache line read with gapped beats A0..A3
      use_base = 1'b1; beat_base = 32'hA0; beat_pct = 60; rdy_pct = 100;
      first_cmd_seen = 1'b0;
      ic_q.push_back(26'h0100);
      settle("t1");
      chk("t1 req-to-cmd latency", 64'(first_cmd_cyc - ic_rdy_cyc), 64'(1));
      chk("t1 cmd addr", 64'(first_cmd_addr), 64'(26'h0100));
      chk("t1 cmd is read", 64'(first_cmd_wr), 64'(0));
      chk("t1 ic beats", 64'(ic_dv_cnt), 64'(4));
      chk("t1 dc beats", 64'(dc_dv_cnt), 64'(0));
      chk("t1 last beat", 64'(last_ic_data), 64'(32'hA3));

      // simultaneous ic read and dc write from reset: D wins, then I
      do_reset();
      beat_pct = 100;
      ic_q.push_back(26'h0200);
      dw_qa.push_back(26'h0300); dw_qd.push_back(32'hDEADBEEF);
      run_grants(2, "t2");
      settle("t2");
      if (glog.size() >= 2 && hs_addr.size() >= 2) begin
         chk("t2 first grant", 64'(glog[0]), 64'(S_DW));
         chk("t2 second grant", 64'(glog[1]), 64'(S_IC));
         chk("t2 write addr", 64'(hs_addr[0]), 64'(26'h0300));
         chk("t2 write data", 64'(hs_wd[0]), 64'(32'hDEADBEEF));
         chk("t2 write flag", 64'(hs_wr[0]), 64'(1));
         chk("t2 read addr", 64'(hs_addr[1]), 64'(26'h0200));
         chk("t2 read flag", 64'(hs_wr[1]), 64'(0));
      end

      // dc read and dc write together: write first
      do_reset();
      dr_q.push_back(26'h0400);
      dw_qa.push_back(26'h0500); dw_qd.push_back(32'h0BADF00D);
      run_grants(2, "t3");
      settle("t3");
      if (glog.size() >= 2) begin
         chk("t3 first grant", 64'(glog[0]), 64'(S_DW));
         chk("t3 second grant", 64'(glog[1]), 64'(S_DR));
      end
      chk("t3 dc beats", 64'(dc_dv_cnt), 64'(4));

      // write command stalled 3 cycles by memory
      do_reset();
      stall_left = 3;
      cmd0 = cmd_cyc;
      dw_qa.push_back(26'h0700); dw_qd.push_back(32'h12345678);
      settle("t4");
      for (int i = 0; i < 4; i++) tick();
      chk("t4 cmd valid cycles", 64'(cmd_cyc - cmd0), 64'(4));
      chk("t4 handshakes", 64'(hs_addr.size()), 64'(1));
      chk("t4 grants", 64'(glog.size()), 64'(1));

      // reset in the middle of a dc read burst, followed by stray beats
      do_reset();
      beat_base = 32'hB0;
      dr_q.push_back(26'h0600);
      for (int i = 0; i < 100 && dc_dv_cnt < 2; i++) tick();
      chk("t5 two beats seen", 64'(dc_dv_cnt), 64'(2));
      rst = 1'b1;
      stray_left = 2;
      tick(); tick();
      rst = 1'b0;
      stray_left = 2;
      for (int i = 0; i < 4; i++) tick();
      chk("t5 no beats after reset", 64'(dc_dv_cnt), 64'(2));
      chk("t5 no ic beats", 64'(ic_dv_cnt), 64'(0));
      glog.delete();
      ic_q.push_back(26'h0900);
      tick(); tick();
      chk("t5 idle grant after reset", 64'(glog.size()), 64'(1));
      settle("t5");

      // continuous ic and dc reads: strict alternation starting with D
      do_reset();
      beat_pct = 70; rdy_pct = 50;
      for (int i = 0; i < 3; i++) begin
         ic_q.push_back(AW'(26'h0800 + i * 16));
         dr_q.push_back(AW'(26'h0A00 + i * 16));
      end
      run_grants(6, "t6");
      settle("t6");
      for (int i = 0; i < 6; i++)
         if (i < glog.size()) chk($sformatf("t6 grant %0d", i), 64'(glog[i]), 64'(exp6[i]));

      // random traffic against the model
      use_base = 1'b0; rand_strays = 1'b1; rdy_pct = 60; beat_pct = 70;
      for (int c = 0; c < 3000; c++) begin
         if (ic_q.size() < 2 && $urandom_range(99) < 15)
            ic_q.push_back(AW'($urandom) & ~AW'(BL - 1));
         if (dr_q.size() < 2 && $urandom_range(99) < 10)
            dr_q.push_back(AW'($urandom) & ~AW'(BL - 1));
         if (dw_qa.size() < 2 && $urandom_range(99) < 10) begin
            dw_qa.push_back(AW'($urandom));
            dw_qd.push_back($urandom);
         end
         tick();
      end
      rand_strays = 1'b0;
      settle("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the core's three memory request ports: i-cache read, d-cache read and d-cache write.
- Serialises those ports onto one external memory command/data port.
- Reads are line bursts of BURST_LEN words. Writes are single words, since the d-cache is write-through.
- Owns fairness between the instruction side and the data side, and routes returned read beats back to the requester.

Parameters:
- ADDR_WIDTH, 26: address width in bits, as presented by the caches.
- DATA_WIDTH, 32: word width in bits.
- BURST_LEN, 4: words returned per read command; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ic_rd_req_valid  in  1  i-cache read request.
- ic_rd_req_addr  in  ADDR_WIDTH  line-aligned read address.
- ic_rd_req_ready  out  1  i-cache request accepted this cycle.
- ic_rd_data_valid  out  1  i-cache read beat valid.
- ic_rd_data  out  DATA_WIDTH  i-cache read beat.
- dc_rd_req_valid  in  1  d-cache read request.
- dc_rd_req_addr  in  ADDR_WIDTH  line-aligned read address.
- dc_rd_req_ready  out  1  d-cache read request accepted.
- dc_rd_data_valid  out  1  d-cache read beat valid.
- dc_rd_data  out  DATA_WIDTH  d-cache read beat.
- dc_wr_req_valid  in  1  d-cache write request.
- dc_wr_req_addr  in  ADDR_WIDTH  write address.
- dc_wr_req_data  in  DATA_WIDTH  write data.
- dc_wr_req_ready  out  1  d-cache write request accepted.
- mem_cmd_valid  out  1  command to memory valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_write  out  1  1 = write, 0 = burst read.
- mem_cmd_addr  out  ADDR_WIDTH  command address.
- mem_cmd_wdata  out  DATA_WIDTH  write data.
- mem_rd_data_valid  in  1  read beat from memory.
- mem_rd_data  in  DATA_WIDTH  read beat data.

Behaviour:
- State machine has four states:
  - IDLE
  - RD_CMD
  - RD_DATA
  - WR_CMD
- Reset values:
  - state IDLE, last_grant_d 0, beat counter 0, owner IC.
  - Registered outputs all 0: mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata.
  - All *_ready and *_data_valid outputs are 0 during reset.
- Reset mid-operation aborts immediately; the in-flight command or burst is dropped.
- IDLE arbitration:
  - Candidates are IR = ic_rd_req_valid and D = dc_wr_req_valid | dc_rd_req_valid. Within D, the write beats the read.
  - If IR and D are both pending: grant IR when last_grant_d=1, else grant D.
  - If only one is pending, grant it.
  - Exactly the granted source's *_req_ready goes high combinationally in IDLE in that same cycle; all other readys stay 0.
  - No ready is asserted outside IDLE.
- On grant:
  - Latch addr, write data and owner; set last_grant_d = (owner != IC).
  - Go to WR_CMD for a write, RD_CMD for a read.
  - mem_cmd_valid rises the cycle after the grant, so request-to-command latency is 1 cycle.
- RD_CMD and WR_CMD:
  - Hold mem_cmd_valid and all mem_cmd_* fields stable until mem_cmd_ready=1.
  - On that handshake, drop mem_cmd_valid next cycle.
  - WR_CMD goes to IDLE; RD_CMD goes to RD_DATA with the beat counter at 0.
- RD_DATA:
  - Each mem_rd_data_valid beat is forwarded combinationally, same cycle, to the owner's *_rd_data and *_rd_data_valid.
  - The non-owner's data_valid stays 0.
  - The beat counter increments per beat (width clog2(BURST_LEN)). On beat BURST_LEN-1 the counter wraps to 0 and state goes to IDLE.
  - A new grant may occur in the IDLE cycle that follows.
  - Beats may be non-contiguous; gaps are allowed.
- mem_rd_data_valid outside RD_DATA is ignored and never forwarded. This covers stale beats after reset and beats arriving in the RD_CMD handshake cycle.
- Memory guarantees the first beat arrives at least 1 cycle after the command handshake.
- *_rd_data outputs carry mem_rd_data unconditionally; only the data_valid signals are gated.
- Requesters hold valid and addr until their ready is seen; the arbiter does not require that valid is held.

Decomposition:
- Package mem_arbiter_pkg holds:
  - typedef enum arb_state_e {IDLE, RD_CMD, RD_DATA, WR_CMD}.
  - typedef enum arb_src_e {SRC_IC, SRC_DR, SRC_DW}.
- One sub-module, mem_arbiter_picker: combinational fairness selection.
  - Inputs: three valids and last_grant_d.
  - Outputs: grant one-hot and grant_any.

Test Plan:
- IC read only: ic req at 0x0100 in cycle 0 → ic_rd_req_ready=1 in cycle 0; cycle 1 mem_cmd_valid=1, write=0, addr 0x0100. With cmd_ready=1, feed 4 beats 0xA0..0xA3 → ic_rd_data_valid on exactly those 4 cycles; dc_rd_data_valid=0 throughout; IDLE after the 4th beat.
- Simultaneous ic read 0x0200 and dc write 0x0300/0xDEADBEEF from reset (last_grant_d=0) → dc_wr_req_ready first and a write cmd. Next grant goes to IC with a read cmd at 0x0200.
- dc_rd and dc_wr pending together, no IC request → write granted first, then read; both take the D path.
- mem_cmd_ready held 0 for 3 cycles during WR_CMD → mem_cmd_valid, addr and wdata stay stable for all 4 cycles; single handshake; no new ready during the stall.
- Assert rst after the 2nd beat of a dc read burst, then send 2 stray beats → all outputs 0 and state IDLE; the stray beats produce no data_valid.
- Continuous ic and dc read requests for 6 grants → grant order D, I, D, I, D, I; no starvation.
